// File: rtl/alu_pkg.sv
// Shared ALU encoding, FSM state type and operation-class helpers for the
// ALU control decoder and the execute-stage ALU.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_SUB   = 4'b0100;
  localparam logic [3:0] ALU_SLL   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_BRCMP = 4'b1010;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_state_t;

  function automatic logic is_shift(input logic [3:0] alusel);
    return (alusel == ALU_SLL) || (alusel == ALU_SRL) || (alusel == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// Iterative 1-bit-per-cycle shifter. The start edge already applies the first
// step, so an n-bit shift finishes on the (n-1)th edge after start.
module alu_serial_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               kill,
  input  logic [3:0]         alusel,
  input  logic [WIDTH-1:0]   din,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               done,
  output logic [WIDTH-1:0]   dout
);

  logic [WIDTH-1:0]   sreg;
  logic [SHAMT_W-1:0] cnt;
  logic               left;
  logic               arith;

  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v,
                                                 input logic l, input logic ar);
    return l ? {v[WIDTH-2:0], 1'b0} : {ar & v[WIDTH-1], v[WIDTH-1:1]};
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg  <= '0;
      cnt   <= '0;
      left  <= 1'b0;
      arith <= 1'b0;
    end else if (kill) begin
      cnt <= '0;
    end else if (start) begin
      sreg  <= shift_one(din, alusel == ALU_SLL, alusel == ALU_SRA);
      cnt   <= shamt - SHAMT_W'(1);
      left  <= (alusel == ALU_SLL);
      arith <= (alusel == ALU_SRA);
    end else if (cnt != '0) begin
      sreg <= shift_one(sreg, left, arith);
      cnt  <= cnt - SHAMT_W'(1);
    end
  end

  // dout is the value the next edge would produce; the top registers it on
  // the edge where the counter steps 1 -> 0.
  assign done = (cnt == SHAMT_W'(1));
  assign dout = shift_one(sreg, left, arith);

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/compare, serial shifts with a
// ready/valid stall, registered result and condition flags.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic [3:0]       alusel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             sign
);

  alu_state_t         state;
  logic               accept;
  logic               long_shift;
  logic [SHAMT_W-1:0] shamt;
  logic               sh_done;
  logic [WIDTH-1:0]   sh_dout;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic               alu_ov;

  assign shamt      = b[SHAMT_W-1:0];
  assign in_ready   = (state == ST_IDLE);
  assign accept     = in_valid && in_ready && !flush;
  assign long_shift = is_shift(alusel) && (shamt >= SHAMT_W'(2));
  assign sum        = {1'b0, a} + {1'b0, b};
  assign diff       = {1'b0, a} - {1'b0, b};

  alu_serial_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shifter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && long_shift),
    .kill   (flush),
    .alusel (alusel),
    .din    (a),
    .shamt  (shamt),
    .done   (sh_done),
    .dout   (sh_dout)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ov    = 1'b0;
    unique case (alusel)
      ALU_AND: alu_res = a & b;
      ALU_OR:  alu_res = a | b;
      ALU_XOR: alu_res = a ^ b;
      ALU_ADD: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ov    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB, ALU_BRCMP: begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = ~diff[WIDTH];
        alu_ov    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      // Only reached with shamt 0 or 1 when actually registered.
      ALU_SLL: alu_res = a << shamt;
      ALU_SRL: alu_res = a >> shamt;
      ALU_SRA: alu_res = WIDTH'($signed(a) >>> shamt);
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      sign      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            if (long_shift) begin
              state <= ST_SHIFT;
            end else begin
              out_valid <= 1'b1;
              result    <= alu_res;
              zero      <= (alu_res == '0);
              carry     <= alu_carry;
              overflow  <= alu_ov;
              sign      <= alu_res[WIDTH-1];
            end
          end
        end
        ST_SHIFT: begin
          // Flush wins over a completion landing on the same edge.
          if (flush) begin
            state <= ST_IDLE;
          end else if (sh_done) begin
            state     <= ST_IDLE;
            out_valid <= 1'b1;
            result    <= sh_dout;
            zero      <= (sh_dout == '0);
            carry     <= 1'b0;
            overflow  <= 1'b0;
            sign      <= sh_dout[WIDTH-1];
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [3:0]  alusel;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic [31:0] result;
  logic        zero, carry, overflow, sign;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] result;
    logic        z, c, v, s;
    int          lat;
    int          low;
    bit          got;
  } txn_t;

  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .alusel    (alusel),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow),
    .sign      (sign)
  );

  always #5 clk = ~clk;

  // Reference model: wide integer arithmetic and whole-word shift operators.
  function automatic txn_t model(input logic [3:0] op, input logic [31:0] av,
                                 input logic [31:0] bv);
    txn_t e;
    longint unsigned ua = {32'd0, av};
    longint unsigned ub = {32'd0, bv};
    longint sa = longint'($signed(av));
    longint sb = longint'($signed(bv));
    longint sr;
    int n = int'(bv[4:0]);
    e.result = '0; e.c = 0; e.v = 0; e.lat = 1; e.low = 0; e.got = 1;
    case (op)
      4'd0: e.result = av & bv;
      4'd1: e.result = av | bv;
      4'd2: begin
        e.result = av + bv;
        e.c = (ua + ub) > 64'hFFFF_FFFF;
        sr = sa + sb;
        e.v = (sr > MAXS) || (sr < MINS);
      end
      4'd3: e.result = av ^ bv;
      4'd4, 4'd10: begin
        e.result = av - bv;
        e.c = (ua >= ub);
        sr = sa - sb;
        e.v = (sr > MAXS) || (sr < MINS);
      end
      4'd5: e.result = av << n;
      4'd6: e.result = av >> n;
      4'd7: e.result = 32'($signed(av) >>> n);
      4'd8: e.result = (sa < sb) ? 32'd1 : 32'd0;
      4'd9: e.result = (ua < ub) ? 32'd1 : 32'd0;
      default: e.result = '0;
    endcase
    if (op inside {4'd5, 4'd6, 4'd7}) begin
      e.lat = (n < 1) ? 1 : n;
      e.low = (n > 1) ? n - 1 : 0;
    end
    e.z = (e.result == 0);
    e.s = e.result[31];
    return e;
  endfunction

  // Issue one op from a negedge and observe until out_valid (bounded).
  task automatic run_op(input logic [3:0] op, input logic [31:0] av,
                        input logic [31:0] bv, output txn_t o);
    o.result = '0; o.z = 0; o.c = 0; o.v = 0; o.s = 0;
    o.lat = 0; o.low = 0; o.got = 0;
    alusel = op; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (out_valid) begin
        o.got = 1; o.lat = k;
        o.result = result; o.z = zero; o.c = carry; o.v = overflow; o.s = sign;
        break;
      end
      if (!in_ready) o.low++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; alusel = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({out_valid, result, zero, carry, overflow, sign, in_ready} !==
        {1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_values: got v=%b r=%h z=%b c=%b o=%b s=%b rdy=%b exp v=0 r=0 z=1 c=0 o=0 s=0 rdy=1",
               out_valid, result, zero, carry, overflow, sign, in_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    txn_t o;
    run_op(4'b0010, 32'h7FFF_FFFF, 32'd1, o);
    tests_run++;
    if (!o.got || o.lat != 1 || {o.result, o.z, o.c, o.v, o.s} !== {32'h8000_0000, 4'b0011}) begin
      tests_failed++;
      $display("FAIL add_overflow: got r=%h zcvs=%b%b%b%b lat=%0d exp r=80000000 zcvs=0011 lat=1",
               o.result, o.z, o.c, o.v, o.s, o.lat);
    end
    run_op(4'b0100, 32'd5, 32'd5, o);
    tests_run++;
    if (!o.got || {o.result, o.z, o.c, o.v, o.s} !== {32'd0, 4'b1100}) begin
      tests_failed++;
      $display("FAIL sub_equal: got r=%h zcvs=%b%b%b%b exp r=0 zcvs=1100", o.result, o.z, o.c, o.v, o.s);
    end
    run_op(4'b1010, 32'd3, 32'd5, o);
    tests_run++;
    if (!o.got || {o.result, o.z, o.c, o.v, o.s} !== {32'hFFFF_FFFE, 4'b0001}) begin
      tests_failed++;
      $display("FAIL brcmp_lt: got r=%h zcvs=%b%b%b%b exp r=fffffffe zcvs=0001", o.result, o.z, o.c, o.v, o.s);
    end
    run_op(4'b0111, 32'h8000_0000, 32'd31, o);
    tests_run++;
    if (!o.got || o.lat != 31 || o.low != 30 || {o.result, o.z, o.c, o.v, o.s} !== {32'hFFFF_FFFF, 4'b0001}) begin
      tests_failed++;
      $display("FAIL sra_31: got r=%h zcvs=%b%b%b%b lat=%0d low=%0d exp r=ffffffff zcvs=0001 lat=31 low=30",
               o.result, o.z, o.c, o.v, o.s, o.lat, o.low);
    end
    run_op(4'b0101, 32'h0000_1234, 32'd0, o);
    tests_run++;
    if (!o.got || o.lat != 1 || o.result !== 32'h0000_1234) begin
      tests_failed++;
      $display("FAIL sll_0: got r=%h lat=%0d exp r=00001234 lat=1", o.result, o.lat);
    end
    run_op(4'b0101, 32'h0000_1234, 32'd1, o);
    tests_run++;
    if (!o.got || o.lat != 1 || o.result !== 32'h0000_2468) begin
      tests_failed++;
      $display("FAIL sll_1: got r=%h lat=%0d exp r=00002468 lat=1", o.result, o.lat);
    end
    run_op(4'b1001, 32'd1, 32'hFFFF_FFFF, o);
    tests_run++;
    if (!o.got || {o.result, o.z, o.c, o.v, o.s} !== {32'd1, 4'b0000}) begin
      tests_failed++;
      $display("FAIL sltu: got r=%h zcvs=%b%b%b%b exp r=1 zcvs=0000", o.result, o.z, o.c, o.v, o.s);
    end
    run_op(4'b1000, 32'd1, 32'hFFFF_FFFF, o);
    tests_run++;
    if (!o.got || {o.result, o.z, o.c, o.v, o.s} !== {32'd0, 4'b1000}) begin
      tests_failed++;
      $display("FAIL slt: got r=%h zcvs=%b%b%b%b exp r=0 zcvs=1000", o.result, o.z, o.c, o.v, o.s);
    end
    run_op(4'b1101, 32'hDEAD_BEEF, 32'h1234_5678, o);
    tests_run++;
    if (!o.got || {o.result, o.z, o.c, o.v, o.s} !== {32'd0, 4'b1000}) begin
      tests_failed++;
      $display("FAIL reserved: got r=%h zcvs=%b%b%b%b exp r=0 zcvs=1000", o.result, o.z, o.c, o.v, o.s);
    end
  endtask

  task automatic test_random();
    txn_t o, e;
    logic [3:0]  op;
    logic [31:0] av, bv;
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15));
      av = $urandom();
      bv = $urandom();
      case ($urandom_range(0, 5))
        0: bv = av;
        1: bv = 32'($urandom_range(0, 3));
        2: av = {1'b1, 31'($urandom())};
        default: ;
      endcase
      e = model(op, av, bv);
      run_op(op, av, bv, o);
      tests_run++;
      if (!o.got || o.lat != e.lat || o.low != e.low ||
          {o.result, o.z, o.c, o.v, o.s} !== {e.result, e.z, e.c, e.v, e.s}) begin
        tests_failed++;
        $display("FAIL random_%0d op=%h a=%h b=%h: got r=%h zcvs=%b%b%b%b lat=%0d low=%0d exp r=%h zcvs=%b%b%b%b lat=%0d low=%0d",
                 i, op, av, bv, o.result, o.z, o.c, o.v, o.s, o.lat, o.low,
                 e.result, e.z, e.c, e.v, e.s, e.lat, e.low);
      end
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL pulse_width_%0d: got out_valid=%b exp 0", i, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    txn_t exp_q[$];
    txn_t e;
    logic [3:0] ops[8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd10};
    for (int i = 0; i <= 6; i++) begin
      if (i > 0) begin
        e = exp_q.pop_front();
        tests_run++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || result !== e.result ||
            {zero, carry, overflow, sign} !== {e.z, e.c, e.v, e.s}) begin
          tests_failed++;
          $display("FAIL back_to_back_%0d: got v=%b rdy=%b r=%h zcvs=%b%b%b%b exp v=1 rdy=1 r=%h zcvs=%b%b%b%b",
                   i, out_valid, in_ready, result, zero, carry, overflow, sign,
                   e.result, e.z, e.c, e.v, e.s);
        end
      end
      if (i < 6) begin
        alusel = ops[$urandom_range(0, 7)];
        a = $urandom(); b = $urandom();
        exp_q.push_back(model(alusel, a, b));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flush();
    txn_t o, e;
    int seen = 0;
    alusel = 4'b0110; a = 32'hF000_0000; b = 32'd20; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_shift_ready: got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
    end
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL flush_no_output: got %0d out_valid pulses exp 0", seen);
    end
    e = model(4'b0010, 32'd100, 32'd23);
    run_op(4'b0010, 32'd100, 32'd23, o);
    tests_run++;
    if (!o.got || o.lat != 1 || o.result !== e.result) begin
      tests_failed++;
      $display("FAIL flush_then_add: got r=%h lat=%0d exp r=%h lat=1", o.result, o.lat, e.result);
    end
    // Flush while idle must swallow the concurrent request.
    alusel = 4'b0010; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || result !== e.result) begin
      tests_failed++;
      $display("FAIL flush_idle: got v=%b r=%h exp v=0 r=%h", out_valid, result, e.result);
    end
  endtask

  task automatic test_reset_midshift();
    txn_t o, e;
    int seen = 0;
    run_op(4'b0011, 32'hFFFF_0000, 32'h0000_FFFF, o);
    alusel = 4'b0111; a = 32'h8000_0000; b = 32'd31; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({out_valid, result, zero, carry, overflow, sign, in_ready} !==
        {1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_midshift: got v=%b r=%h z=%b c=%b o=%b s=%b rdy=%b exp v=0 r=0 z=1 c=0 o=0 s=0 rdy=1",
               out_valid, result, zero, carry, overflow, sign, in_ready);
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (out_valid || !in_ready) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL reset_release_quiet: got %0d bad cycles exp 0", seen);
    end
    e = model(4'b0101, 32'h0000_0003, 32'd4);
    run_op(4'b0101, 32'h0000_0003, 32'd4, o);
    tests_run++;
    if (!o.got || o.lat != 4 || o.low != 3 || o.result !== e.result) begin
      tests_failed++;
      $display("FAIL after_reset_sll: got r=%h lat=%0d low=%0d exp r=%h lat=4 low=3",
               o.result, o.lat, o.low, e.result);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_midshift();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
